// File: rtl/xtea_stream_if.sv
// Word-stream wrapper around a 128-bit XTEA block encryptor: packs four input words into a block,
// runs the encryptor once, then streams four ciphertext words out. Define XTEA_CBC_EN for CBC chaining.
module xtea_stream_if (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  input  logic         clear_chain,
  output logic         enc_en,
  output logic         enc_start,
  output logic [127:0] enc_data,
  input  logic         enc_ready,
  input  logic [127:0] enc_result
);

  // Handshake: a word moves on in_* or out_* in a cycle where valid and ready are both high;
  // valid and data stay stable until that transfer, and ready never depends on valid.
  typedef enum logic [2:0] {FILL, START, WAIT, CAPT, DRAIN} state_e;

  state_e       state_q;
  logic [1:0]   in_cnt_q;
  logic [1:0]   out_idx_q;
  logic [1:0]   out_idx_d;
  logic [127:0] asm_q;
  logic [127:0] obuf_q;
  logic         in_rdy_q;
  logic         out_valid_q;
  logic [31:0]  out_data_q;
  logic         enc_en_q;
  logic         enc_start_q;
  logic [127:0] enc_data_q;
  logic [127:0] blk_d;
  logic [127:0] enc_data_d;
  logic         in_fire;
  logic         out_fire;

  assign in_ready  = in_rdy_q && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign enc_en    = enc_en_q;
  assign enc_start = enc_start_q;
  assign enc_data  = enc_data_q;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign out_idx_d = out_idx_q + 2'd1;

  // Word n lands at bit offset 32*(3-n), i.e. word 0 is the most significant.
  always_comb begin
    blk_d = asm_q;
    blk_d[{~in_cnt_q, 5'd0} +: 32] = in_data;
  end

`ifdef XTEA_CBC_EN
  logic [127:0] chain_q;
  logic         clear_ok;

  assign clear_ok = clear_chain && (state_q == FILL) && (in_cnt_q == 2'd0);

  always_ff @(posedge clock) begin
    if (reset || clear_ok) begin
      chain_q <= '0;
    end else if (state_q == CAPT) begin
      chain_q <= enc_result;
    end
  end

  assign enc_data_d = blk_d ^ chain_q;
`else
  logic unused_clear;
  assign unused_clear = clear_chain;
  assign enc_data_d   = blk_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      in_cnt_q    <= 2'd0;
      out_idx_q   <= 2'd0;
      asm_q       <= '0;
      obuf_q      <= '0;
      in_rdy_q    <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      enc_en_q    <= 1'b0;
      enc_start_q <= 1'b0;
      enc_data_q  <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_fire) begin
            asm_q    <= blk_d;
            in_cnt_q <= in_cnt_q + 2'd1;
            if (in_cnt_q == 2'd3) begin
              state_q     <= START;
              in_rdy_q    <= 1'b0;
              enc_en_q    <= 1'b1;
              enc_start_q <= 1'b1;
              enc_data_q  <= enc_data_d;
            end
          end
        end
        START: begin
          enc_en_q    <= 1'b0;
          enc_start_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (enc_ready) begin
            state_q <= CAPT;
          end
        end
        // The encryptor's result register settles on the same edge as its ready pulse,
        // so the result is only safe to sample one cycle later.
        CAPT: begin
          obuf_q      <= enc_result;
          out_data_q  <= enc_result[127:96];
          out_valid_q <= 1'b1;
          out_idx_q   <= 2'd0;
          state_q     <= DRAIN;
        end
        DRAIN: begin
          if (out_fire) begin
            out_idx_q <= out_idx_d;
            if (out_idx_q == 2'd3) begin
              out_valid_q <= 1'b0;
              in_rdy_q    <= 1'b1;
              state_q     <= FILL;
            end else begin
              out_data_q <= obuf_q[{~out_idx_d, 5'd0} +: 32];
            end
          end
        end
        default: begin
          state_q     <= FILL;
          in_cnt_q    <= 2'd0;
          out_idx_q   <= 2'd0;
          in_rdy_q    <= 1'b1;
          out_valid_q <= 1'b0;
          enc_en_q    <= 1'b0;
          enc_start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xtea_stream_if.sv
// Bench for xtea_stream_if: random word streams, a behavioural encryptor with random latency,
// and a cycle-by-cycle scoreboard of the expected handshake and data behaviour.
`timescale 1ns/1ps
module tb_xtea_stream_if;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         clear_chain = 1'b0;
  logic         enc_en;
  logic         enc_start;
  logic [127:0] enc_data;
  logic         enc_ready = 1'b0;
  logic [127:0] enc_result = '0;

  xtea_stream_if dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .clear_chain(clear_chain),
    .enc_en     (enc_en),
    .enc_start  (enc_start),
    .enc_data   (enc_data),
    .enc_ready  (enc_ready),
    .enc_result (enc_result)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus controls shared with the encryptor and sink processes
  logic [127:0] res_q[$];
  int           lat_fix = 0;
  bit           force_pulse = 0;
  int           stall_left = 0;
  bit           rand_out = 0;

  // observations recorded by the compare process
  logic [127:0] start_log[$];
  logic [31:0]  out_log[$];
  int           stall_seen = 0;

  // expected ciphertext words, oldest first
  logic [31:0]  exp_q[$];

  localparam logic [127:0] R_CBC = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- behavioural encryptor ----------------
  initial begin : encryptor
    int left;
    bit rst_now, start_now;
    left = 0;
    forever begin
      @(negedge clock);
      rst_now   = reset;
      start_now = enc_start;
      @(posedge clock);
      #1;
      enc_ready = 1'b0;
      if (rst_now) begin
        left = 0;
      end else begin
        if (start_now) left = (lat_fix > 0) ? lat_fix : $urandom_range(1, 5);
        if (left > 0) begin
          left--;
          if (left == 0) begin
            enc_ready = 1'b1;
            if (res_q.size() > 0) enc_result = res_q.pop_front();
            else enc_result = rand128();
          end
        end
      end
      if (force_pulse && left == 0 && !enc_ready) begin
        force_pulse = 0;
        enc_ready   = 1'b1;
        enc_result  = rand128();
      end
    end
  end

  // ---------------- downstream sink ----------------
  initial begin : sink
    forever begin
      @(posedge clock);
      #1;
      if (stall_left > 0 && out_valid && out_data == 32'hBBBBBBBB) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_out) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  initial begin : compare
    logic [127:0] asm_m, chain_m, enc_hold_m, enc_exp_m;
    int cnt_m, capt_m;
    bit busy_m, start_due_m, wait_m, rst_prev, exp_ov, idle;
    asm_m = '0; chain_m = '0; enc_hold_m = '0; enc_exp_m = '0;
    cnt_m = 0; capt_m = 0;
    busy_m = 0; start_due_m = 0; wait_m = 0; rst_prev = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("in_ready_in_reset", in_ready, 1'b0);
        if (rst_prev) begin
          chk("rst_out_valid", out_valid, 1'b0);
          chk("rst_out_data", out_data, 32'h0);
          chk("rst_enc_en", enc_en, 1'b0);
          chk("rst_enc_start", enc_start, 1'b0);
          chk("rst_enc_data", enc_data, 128'h0);
        end
        asm_m = '0; chain_m = '0; enc_hold_m = '0; enc_exp_m = '0;
        cnt_m = 0; capt_m = 0;
        busy_m = 0; start_due_m = 0; wait_m = 0;
        exp_q.delete();
        rst_prev = 1;
      end else begin
        rst_prev = 0;
        if (capt_m > 0) capt_m--;
        idle = !busy_m;
        chk("in_ready", in_ready, idle);
        chk("enc_start", enc_start, start_due_m);
        chk("enc_en", enc_en, start_due_m);
        if (start_due_m) begin
          enc_hold_m = enc_exp_m;
          start_log.push_back(enc_data);
          start_due_m = 0;
          wait_m = 1;
        end
        chk("enc_data", enc_data, enc_hold_m);
        exp_ov = (exp_q.size() > 0) && (capt_m == 0);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
          chk("out_data", out_data, exp_q[0]);
          if (!out_ready && out_data == 32'hBBBBBBBB && !in_ready) stall_seen++;
          if (out_ready) begin
            out_log.push_back(out_data);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) busy_m = 0;
          end
        end
        if (enc_ready && wait_m) begin
          wait_m = 0;
          capt_m = 2;
`ifdef XTEA_CBC_EN
          chain_m = enc_result;
`endif
          for (int i = 0; i < 4; i++) exp_q.push_back(enc_result[127 - 32*i -: 32]);
        end
        if (idle && clear_chain && cnt_m == 0) chain_m = '0;
        if (idle && in_valid) begin
          asm_m[(3 - cnt_m)*32 +: 32] = in_data;
          cnt_m++;
          if (cnt_m == 4) begin
            cnt_m = 0;
            enc_exp_m = asm_m ^ chain_m;
            start_due_m = 1;
            busy_m = 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    bit acc;
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = w;
    acc = 0;
    n = 0;
    while (!acc && n < 300) begin
      @(negedge clock);
      acc = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL send_word_timeout: got no in_ready required in_ready=1 within 300 cycles");
    end
  endtask

  task automatic send_block(input logic [127:0] b, input int gmax);
    for (int i = 0; i < 4; i++) send_word(b[127 - 32*i -: 32], $urandom_range(0, gmax));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_valid || !in_ready || enc_start) && n < 400) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= 400) begin
      n_bad++;
      $display("FAIL idle_timeout: got busy required idle within 400 cycles");
    end
  endtask

  task automatic pulse_clear();
    clear_chain = 1'b1;
    step();
    clear_chain = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int ns, no;
    logic [127:0] exp2;
    repeat (3) step();
    reset = 1'b0;
    step();

    // known-answer block with a five-cycle stall on word 1
    res_q.push_back(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    stall_left = 5;
    lat_fix = 3;
    ns = start_log.size();
    no = out_log.size();
    send_block(128'h01234567_89ABCDEF_FEDCBA98_76543210, 0);
    wait_idle();
    chk("kat_start_count", start_log.size(), ns + 1);
    if (start_log.size() > ns)
      chk("kat_enc_data", start_log[ns], 128'h0123456789ABCDEFFEDCBA9876543210);
    chk("kat_out_count", out_log.size(), no + 4);
    if (out_log.size() >= no + 4) begin
      chk("kat_out_w0", out_log[no],     32'hAAAAAAAA);
      chk("kat_out_w1", out_log[no + 1], 32'hBBBBBBBB);
      chk("kat_out_w2", out_log[no + 2], 32'hCCCCCCCC);
      chk("kat_out_w3", out_log[no + 3], 32'hDDDDDDDD);
    end
    chk("kat_stall_cycles", stall_seen, 5);
    lat_fix = 0;

    // stray enc_ready while filling, both idle and mid-block
    ns = start_log.size();
    no = out_log.size();
    force_pulse = 1;
    repeat (6) step();
    chk("stray_ready_no_start", start_log.size(), ns);
    chk("stray_ready_no_out", out_log.size(), no);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    force_pulse = 1;
    repeat (4) step();
    send_word(32'h33333333, 0);
    send_word(32'h44444444, 0);
    wait_idle();
    chk("partial_fill_out", out_log.size(), no + 4);

    // reset in the middle of filling abandons the partial block
    no = out_log.size();
    send_word(32'hDEADBEEF, 0);
    send_word(32'hCAFEF00D, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    send_block(rand128(), 1);
    wait_idle();
    chk("midfill_reset_out", out_log.size(), no + 4);

    // random traffic with backpressure, gaps and stray clears
    rand_out = 1;
    for (int b = 0; b < 25; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) wait_idle();
        pulse_clear();
      end
      send_block(rand128(), 2);
    end
    wait_idle();
    rand_out = 0;

    // chaining: zero blocks after a clear
    pulse_clear();
    res_q.push_back(R_CBC);
    ns = start_log.size();
    send_block(128'h0, 0);
    wait_idle();
    send_block(128'h0, 0);
    wait_idle();
    pulse_clear();
    send_block(128'h0, 0);
    wait_idle();
`ifdef XTEA_CBC_EN
    exp2 = R_CBC;
`else
    exp2 = 128'h0;
`endif
    chk("cbc_start_count", start_log.size(), ns + 3);
    if (start_log.size() >= ns + 3) begin
      chk("cbc_blk1", start_log[ns], 128'h0);
      chk("cbc_blk2", start_log[ns + 1], exp2);
      chk("cbc_blk3", start_log[ns + 2], 128'h0);
    end

    // reset while the encryptor is busy, then a late ready pulse
    lat_fix = 20;
    no = out_log.size();
    send_block(rand128(), 0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    force_pulse = 1;
    @(negedge clock);
    chk("in_ready_after_reset", in_ready, 1'b1);
    repeat (12) step();
    chk("wait_reset_no_out", out_log.size(), no);
    lat_fix = 0;
    send_block(rand128(), 0);
    wait_idle();
    chk("recover_out", out_log.size(), no + 4);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got no end of run required end before 500000 ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xtea_stream_if.md
XTEA_STREAM_IF -- requirements
Module: xtea_stream_if

Interface
REQ-001 SHALL have port clock, input, 1, single rising-edge clock for all logic.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high; sampled on clock rising edge only.
REQ-003 SHALL have port in_valid, input, 1, upstream word valid.
REQ-004 SHALL have port in_ready, output, 1, block accepts word; transfer occurs when in_valid and in_ready are both high.
REQ-005 SHALL have port in_data, input, 32, plaintext word.
REQ-006 SHALL have port out_valid, output, 1, ciphertext word valid.
REQ-007 SHALL have port out_ready, input, 1, downstream accepts word.
REQ-008 SHALL have port out_data, output, 32, ciphertext word.
REQ-009 SHALL have port clear_chain, input, 1, chaining-value clear request.
REQ-010 SHALL have port enc_en, output, 1, encryptor enable.
REQ-011 SHALL have port enc_start, output, 1, encryptor start.
REQ-012 SHALL have port enc_data, output, 128, block presented to encryptor data_i.
REQ-013 SHALL have port enc_ready, input, 1, encryptor one-cycle completion pulse.
REQ-014 SHALL have port enc_result, input, 128, encryptor data_o.

Function
REQ-015 SHALL implement FSM states FILL, START, WAIT, CAPT and DRAIN.
REQ-016 FILL: in_ready=1; words are accepted into a 2-bit counter; word 0 goes to bits [127:96] and word 3 to bits [31:0]; the FSM moves to START on acceptance of word 3.
REQ-017 START: enc_start=1 and enc_en=1 for exactly one cycle; enc_data is stable; next state is WAIT.
REQ-018 enc_data SHALL hold its value in every state other than FILL.
REQ-019 WAIT: enc_start=0; the FSM stays until enc_ready=1, then moves to CAPT.
REQ-020 CAPT: enc_result is latched into the output buffer in this cycle, because the encryptor result register updates on the same edge as its ready pulse; next state is DRAIN.
REQ-021 DRAIN: out_valid=1; out_data is buffer [127:96], [95:64], [63:32], [31:0] in order; the index advances only on out_valid && out_ready; out_data is held while out_ready=0; the FSM returns to FILL after word 3 is accepted.
REQ-022 in_ready SHALL be 0 outside FILL, so at most one block is in flight.
REQ-023 Word counters SHALL wrap 3->0.
REQ-024 An enc_ready pulse outside WAIT SHALL be ignored.
REQ-025 clear_chain SHALL be honoured only in FILL with word counter 0; elsewhere it is ignored.
REQ-026 Minimum block throughput SHALL be 4 (fill) + 1 (START) + encryptor latency + 1 (CAPT) + 4 (drain) cycles.

Reset
REQ-027 On reset the block SHALL enter FILL with counters 0, assembly and output buffers 0, and chain register 0.
REQ-028 Reset values of outputs SHALL be: in_ready=0 during the reset cycle and 1 in the following cycle; out_valid=0; out_data=0; enc_en=0; enc_start=0; enc_data=0.
REQ-029 Reset mid-operation SHALL abandon any partial or in-flight block; no word of it is ever emitted.
REQ-030 The encryptor SHALL share the same reset so that both return to idle together.

Configuration
REQ-031 Macro XTEA_CBC_EN SHALL select chaining.
REQ-032 When XTEA_CBC_EN is defined: enc_data = assembled block XOR chain register; the chain register loads enc_result in CAPT; clear_chain per REQ-025 sets the chain register to 0.
REQ-033 When XTEA_CBC_EN is undefined: enc_data = assembled block; no chain register exists; the clear_chain port is present but ignored.

Verification
REQ-034 Reset then feed words 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210 -> enc_data=0x0123456789ABCDEFFEDCBA9876543210 with a single-cycle enc_start.
REQ-035 Encryptor model returns 0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD -> out_data emits 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD in order.
REQ-036 Hold out_ready=0 for 5 cycles during word 1 -> out_data stays 0xBBBBBBBB, out_valid stays 1, and in_ready stays 0.
REQ-037 With XTEA_CBC_EN, send two all-zero blocks while the model returns R for block 1 -> the second enc_data equals R; after clear_chain=1 the third all-zero block gives enc_data=0.
REQ-038 Assert reset while in WAIT, then pulse enc_ready -> no out_valid occurs and in_ready=1 in the cycle after reset is released.
REQ-039 Pulse enc_ready while in FILL -> no state change and no output.
